// File: rtl/top_level.sv
// Four-way stoplight controller with protected left-turn phases.
// Ports: CLK, rst (sync, active-low), eight presence inputs,
//   eight 2-bit light drives, 5-bit state code.
module top_level #(
   parameter int GREEN_TIME  = 8,
   parameter int YELLOW_TIME = 3
) (
   input  logic       CLK,
   input  logic       rst,
   input  logic       e_presence,
   input  logic       w_presence,
   input  logic       n_presence,
   input  logic       s_presence,
   input  logic       el_presence,
   input  logic       wl_presence,
   input  logic       nl_presence,
   input  logic       sl_presence,
   output logic [1:0] east,
   output logic [1:0] west,
   output logic [1:0] north,
   output logic [1:0] south,
   output logic [1:0] eastLeft,
   output logic [1:0] westLeft,
   output logic [1:0] northLeft,
   output logic [1:0] southLeft,
   output logic [4:0] state
);

   localparam logic [4:0] EW_G  = 5'd0;
   localparam logic [4:0] EW_Y  = 5'd1;
   localparam logic [4:0] NS_G  = 5'd2;
   localparam logic [4:0] NS_Y  = 5'd3;
   localparam logic [4:0] EWL_G = 5'd4;
   localparam logic [4:0] EWL_Y = 5'd5;
   localparam logic [4:0] NSL_G = 5'd6;
   localparam logic [4:0] NSL_Y = 5'd7;

   localparam logic [1:0] RED = 2'b00;
   localparam logic [1:0] YEL = 2'b01;
   localparam logic [1:0] GRN = 2'b10;

   localparam logic [7:0] G_LAST = 8'(GREEN_TIME - 1);
   localparam logic [7:0] Y_LAST = 8'(YELLOW_TIME - 1);

   logic [4:0] state_q;
   logic [4:0] state_d;
   logic [7:0] timer;
   logic [3:0] dem;
   logic [1:0] phase;
   logic       yellow;
   logic       compete;

   // Phase index: 0=EW, 1=NS, 2=EWL, 3=NSL; state code = {phase, yellow}.
   assign dem[0] = e_presence  | w_presence;
   assign dem[1] = n_presence  | s_presence;
   assign dem[2] = el_presence | wl_presence;
   assign dem[3] = nl_presence | sl_presence;

   assign phase   = state_q[2:1];
   assign yellow  = state_q[0];
   assign compete = |(dem & ~(4'b0001 << phase));

   // First phase after p in cyclic order with demand; p itself if none.
   // Scanning from the farthest back toward p+1 lets the nearest win.
   function automatic logic [1:0] next_phase(
      input logic [1:0] p,
      input logic [3:0] d
   );
      logic [1:0] q;
      next_phase = p;
      for (int k = 3; k >= 1; k--) begin
         q = p + 2'(k);
         if (d[q])
            next_phase = q;
      end
   endfunction

   always_comb begin
      state_d = state_q;
      if (!yellow) begin
         if (timer >= G_LAST && compete)
            state_d = {2'b00, phase, 1'b1};
      end else begin
         if (timer == Y_LAST)
            state_d = {2'b00, next_phase(phase, dem), 1'b0};
      end
   end

   always_ff @(posedge CLK) begin
      if (!rst) begin
         state_q <= EW_G;
         timer   <= 8'd0;
      end else begin
         state_q <= state_d;
         if (state_d != state_q)
            timer <= 8'd0;
         else if (timer != 8'hff)
            timer <= timer + 8'd1;
      end
   end

   assign state = state_q;

   always_comb begin
      east      = RED;
      west      = RED;
      north     = RED;
      south     = RED;
      eastLeft  = RED;
      westLeft  = RED;
      northLeft = RED;
      southLeft = RED;
      unique case (state_q)
         EW_G:  begin east = GRN; west = GRN; end
         EW_Y:  begin east = YEL; west = YEL; end
         NS_G:  begin north = GRN; south = GRN; end
         NS_Y:  begin north = YEL; south = YEL; end
         EWL_G: begin eastLeft = GRN; westLeft = GRN; end
         EWL_Y: begin eastLeft = YEL; westLeft = YEL; end
         NSL_G: begin northLeft = GRN; southLeft = GRN; end
         NSL_Y: begin northLeft = YEL; southLeft = YEL; end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_top_level.sv
// Bench for the stoplight controller: phase-level model
// checked every cycle, plus directed dwell/sequence checks.
module tb_top_level;

   localparam int G = 8;
   localparam int Y = 3;

   logic CLK = 1'b0;
   logic rst = 1'b0;
   logic e, w, n, s, el, wl, nl, sl;
   logic [1:0] east, west, north, south;
   logic [1:0] eastLeft, westLeft, northLeft, southLeft;
   logic [4:0] state;

   int total = 0;
   int bad   = 0;

   always #5 CLK = ~CLK;

   top_level #(.GREEN_TIME(G), .YELLOW_TIME(Y)) dut (
      .CLK(CLK), .rst(rst),
      .e_presence(e), .w_presence(w),
      .n_presence(n), .s_presence(s),
      .el_presence(el), .wl_presence(wl),
      .nl_presence(nl), .sl_presence(sl),
      .east(east), .west(west), .north(north), .south(south),
      .eastLeft(eastLeft), .westLeft(westLeft),
      .northLeft(northLeft), .southLeft(southLeft),
      .state(state)
   );

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Model: which phase is served, whether it is in yellow, and how
   // many clock edges it has spent in the current light.
   int  m_ph = 0;
   bit  m_yel = 0;
   int  m_cnt = 0;
   bit  m_ok = 0;

   always @(posedge CLK) begin
      bit want[4];
      bit others;
      int nxt;
      want[0] = e | w;
      want[1] = n | s;
      want[2] = el | wl;
      want[3] = nl | sl;
      if (!rst) begin
         m_ph = 0; m_yel = 0; m_cnt = 0; m_ok = 1;
      end else if (!m_yel) begin
         others = 0;
         for (int i = 0; i < 4; i++)
            if (i != m_ph && want[i]) others = 1;
         if (m_cnt + 1 >= G && others) begin
            m_yel = 1; m_cnt = 0;
         end else m_cnt++;
      end else if (m_cnt + 1 == Y) begin
         nxt = m_ph;
         for (int k = 3; k >= 1; k--)
            if (want[(m_ph + k) % 4]) nxt = (m_ph + k) % 4;
         m_ph = nxt; m_yel = 0; m_cnt = 0;
      end else m_cnt++;
   end

   function automatic logic [20:0] expect_vec(int ph, bit yl);
      logic [1:0] lt[8];
      logic [1:0] v;
      v = yl ? 2'b01 : 2'b10;
      for (int i = 0; i < 8; i++) lt[i] = 2'b00;
      lt[2 * ph] = v;
      lt[2 * ph + 1] = v;
      return {5'(2 * ph + int'(yl)), lt[0], lt[1], lt[2], lt[3],
              lt[4], lt[5], lt[6], lt[7]};
   endfunction

   always @(negedge CLK) begin
      if (m_ok)
         chk("model", int'({state, east, west, north, south,
                            eastLeft, westLeft, northLeft, southLeft}),
             int'(expect_vec(m_ph, m_yel)));
   end

   task automatic cyc();
      @(posedge CLK);
      #2;
   endtask

   task automatic setp(input logic [7:0] v);
      {e, w, n, s, el, wl, nl, sl} = v;
   endtask

   // Count cycles the DUT holds `code`, entry cycle included.
   task automatic dwell(input int code, output int cnt);
      cnt = 1;
      cyc();
      while (state == 5'(code) && cnt < 300) begin
         cnt++;
         cyc();
      end
   endtask

   task automatic wait_for(input int code, input string name);
      int k = 0;
      while (state != 5'(code) && k < 300) begin
         cyc();
         k++;
      end
      chk(name, int'(state), code);
   endtask

   int d;
   int nz;
   int seq_code[7] = '{1, 2, 3, 4, 5, 6, 7};
   int seq_len[7]  = '{3, 8, 3, 8, 3, 8, 3};

   initial begin
      setp(8'h00);
      rst = 1'b0;
      cyc();
      chk("reset_state", int'(state), 0);
      chk("reset_ew", int'({east, west}), 4'b1010);
      chk("reset_rest", int'({north, south, eastLeft, westLeft,
                              northLeft, southLeft}), 0);
      rst = 1'b1;

      setp(8'b1100_0000);
      nz = 0;
      for (int i = 0; i < 15; i++) begin
         cyc();
         if (state != 5'd0) nz++;
      end
      chk("hold_nonzero_cycles", nz, 0);

      setp(8'hff);
      cyc();
      chk("all_enter_ewy", int'(state), 1);
      for (int i = 0; i < 7; i++) begin
         dwell(seq_code[i], d);
         chk($sformatf("all_dwell_%0d", seq_code[i]), d, seq_len[i]);
         chk($sformatf("all_after_%0d", seq_code[i]), int'(state),
             (seq_code[i] + 1) % 8);
      end

      setp(8'b0000_0010);
      dwell(0, d);
      chk("skip_green_len", d, 8);
      dwell(1, d);
      chk("skip_yellow_len", d, 3);
      chk("skip_to_nslg", int'(state), 6);
      chk("skip_nsl_lights", int'({northLeft, southLeft}), 4'b1010);
      chk("skip_ew_red", int'({east, west}), 0);

      setp(8'b1000_0000);
      wait_for(0, "back_to_ewg");
      setp(8'b0010_0000);
      dwell(0, d);
      chk("wd_green_len", d, 8);
      setp(8'h00);
      dwell(1, d);
      chk("wd_yellow_len", d, 3);
      chk("wd_return_ewg", int'(state), 0);
      repeat (5) cyc();
      chk("wd_holds", int'(state), 0);

      setp(8'b1001_0000);
      wait_for(3, "reach_nsy");
      rst = 1'b0;
      cyc();
      rst = 1'b1;
      chk("midy_reset_state", int'(state), 0);
      chk("midy_reset_lights", int'({east, west, north, south, eastLeft,
                                     westLeft, northLeft, southLeft}),
          16'b1010_0000_0000_0000);
      setp(8'h00);
      repeat (4) cyc();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/top_level.md
# top_level

Four-way intersection stoplight controller with protected left-turn phases. It cycles through four green phases (east/west through, north/south through, east/west left, north/south left), each followed by a yellow interval. Phases with no waiting vehicle are skipped, and a green is held indefinitely while no other approach has demand. It is the top of the stoplight design: presence sensors in, eight 2-bit light drives and a state code out.

## Interface
- GREEN_TIME, 8, minimum green duration in clock cycles (1..255)
- YELLOW_TIME, 3, yellow duration in clock cycles (1..255)

- CLK  in  1  system clock; all logic on its rising edge
- rst  in  1  reset; synchronous, active-low (rst=0 sampled at a rising edge resets)
- e_presence, w_presence, n_presence, s_presence  in  1 each  through-lane vehicle present
- el_presence, wl_presence, nl_presence, sl_presence  in  1 each  left-turn-lane vehicle present
- east, west, north, south  out  2 each  through lights
- eastLeft, westLeft, northLeft, southLeft  out  2 each  left-turn arrows
- state  out  5  current FSM state code

## Operation
- Light encoding: 2'b00 red, 2'b01 yellow, 2'b10 green; 2'b11 is never driven.
- Phase demands:
  - D_EW = e|w
  - D_NS = n|s
  - D_EWL = el|wl
  - D_NSL = nl|sl
- States and codes; upper state bits are always 0:
  - EW_G=0, EW_Y=1
  - NS_G=2, NS_Y=3
  - EWL_G=4, EWL_Y=5
  - NSL_G=6, NSL_Y=7
- Cyclic phase order: EW → NS → EWL → NSL → EW.
- Light outputs are a pure decode of the state register. Every light not listed below is red.
  - EW_G / EW_Y: east=west=green / yellow.
  - NS_G / NS_Y: north=south=green / yellow.
  - EWL_G / EWL_Y: eastLeft=westLeft=green / yellow.
  - NSL_G / NSL_Y: northLeft=southLeft=green / yellow.
- A single 8-bit cycle counter `timer` is cleared on every state change and otherwise increments, saturating at 255.
- Green state X_G:
  - If timer ≥ GREEN_TIME-1 and any other phase's demand is 1, go to X_Y.
  - Otherwise stay in X_G. The green holds indefinitely with no competing demand, even if the phase's own demand is 0.
- Yellow state X_Y:
  - When timer = YELLOW_TIME-1, go to the green of the first phase after X in cyclic order whose demand is 1, at the moment of transition.
  - If no other phase has demand at that moment, return to X_G.
  - Phases without demand are skipped; e.g. with only D_EWL and D_EW set, EW_Y goes straight to EWL_G.
- Simultaneous demands are resolved purely by cyclic order from the current phase; there is no other priority.
- Presence inputs are sampled synchronously with no latching. Demand that drops before a decision point is ignored.

## Timing
- Reset (rst=0 at a rising edge), from the cycle after reset onward:
  - state=EW_G (0), timer=0.
  - east=west=2'b10; all other lights 2'b00.
- Reset mid-operation, including during a yellow, forces EW_G on that edge; the interrupted phase is not completed.
- The state register and outputs update on the same rising edge; no extra output latency.
- Minimum green lasts exactly GREEN_TIME cycles when competing demand is present from entry. Otherwise the green lasts until GREEN_TIME cycles have elapsed and competing demand appears, leaving on the edge that samples the demand.
- Yellow lasts exactly YELLOW_TIME cycles.
- With all eight presences held at 1 and default parameters, one full cycle takes 4×(8+3)=44 clocks.

## Test plan
- Reset: rst=0 for 1 edge with all presences 0 → state=0, east=west=2'b10, the other six lights 2'b00.
- Hold with no competition: rst=1, e=w=1, all else 0, for 15 cycles → state stays 0, east/west green throughout; NS states never appear.
- All demand: set all presences to 1 after the hold → EW_Y for 3 cycles, then NS_G 8, NS_Y 3, EWL_G 8, EWL_Y 3, NSL_G 8, NSL_Y 3, back to EW_G; state sequence 1,2,3,4,5,6,7,0.
- Skip: in EW_G, only nl=1 (after ≥8 cycles) → EW_Y for 3 cycles, then NSL_G (state 6) with northLeft=southLeft=2'b10.
- Demand withdrawn: in EW_G assert n=1 → EW_Y; deassert n before yellow ends, no other demand → returns to EW_G (state 0).
- Reset mid-yellow: rst=0 while in state 3 → next edge state=0, only east/west green.
